// File: rtl/sprite_line_renderer.sv
// Double-buffered scanline sprite renderer: while one line buffer is shown,
// the next line is composed into the other from the active descriptor set.
module sprite_line_renderer #(
  parameter int                 NUM_SPRITES = 8,
  parameter int                 SPRITE_SIZE = 32,
  parameter int                 H_ACTIVE    = 640,
  parameter int                 V_ACTIVE    = 480,
  parameter int                 V_TOTAL     = 525,
  parameter int                 COLOR_W     = 24,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  parameter logic [COLOR_W-1:0] BG_COLOR    = '0
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 desc_we,
  input  logic [$clog2(NUM_SPRITES)-1:0]                       desc_addr,
  input  logic [20:0]                                          desc_data,
  input  logic [9:0]                                           VGA_HCOUNT,
  input  logic [9:0]                                           VGA_VCOUNT,
  output logic [$clog2(NUM_SPRITES)+2*$clog2(SPRITE_SIZE)-1:0] pix_addr,
  output logic                                                 pix_rd,
  input  logic [COLOR_W-1:0]                                   pix_data,
  output logic [COLOR_W/3-1:0]                                 VGA_R,
  output logic [COLOR_W/3-1:0]                                 VGA_G,
  output logic [COLOR_W/3-1:0]                                 VGA_B,
  output logic                                                 overrun
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int SW = $clog2(SPRITE_SIZE);
  localparam int AW = IW + 2 * SW;
  localparam int CW = COLOR_W / 3;
  localparam int HW = $clog2(H_ACTIVE);

  localparam logic [10:0]   H_ACT11    = 11'(H_ACTIVE);
  localparam logic [10:0]   H_LAST11   = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   SIZE11     = 11'(SPRITE_SIZE);
  localparam logic [10:0]   SIZE_M1_11 = 11'(SPRITE_SIZE - 1);
  localparam logic [9:0]    V_ACT10    = 10'(V_ACTIVE);
  localparam logic [9:0]    V_LAST10   = 10'(V_TOTAL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_SPRITES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Descriptor sets: shadow is CPU-writable, active is what rendering uses.
  logic       shd_en_q [NUM_SPRITES];
  logic [9:0] shd_x_q  [NUM_SPRITES];
  logic [9:0] shd_y_q  [NUM_SPRITES];
  logic       act_en_q [NUM_SPRITES];
  logic [9:0] act_x_q  [NUM_SPRITES];
  logic [9:0] act_y_q  [NUM_SPRITES];

  logic [COLOR_W-1:0] lb0_mem [H_ACTIVE];
  logic [COLOR_W-1:0] lb1_mem [H_ACTIVE];

  logic [9:0]         vcount_q;
  logic               disp_sel_q;
  logic [1:0]         rendered_q, rendered_d;
  logic               overrun_q;
  logic [2:0]         state_q, state_d;
  logic [9:0]         t_q, t_d;
  logic [10:0]        cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [SW-1:0]      row_q, row_d;
  logic               pix_rd_q, pix_rd_d;
  logic [AW-1:0]      pix_addr_q, pix_addr_d;
  logic [COLOR_W-1:0] vga_q;

  logic               line_evt;
  logic               commit;
  logic               busy;
  logic [9:0]         t_next;
  logic [10:0]        t11, sy11, wx, cnt_inc;
  logic [SW-1:0]      row_off;
  logic               hit;
  logic               wr_en;
  logic [HW-1:0]      wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               disp_now;
  logic [10:0]        hcount11;
  logic [COLOR_W-1:0] disp_pix;
  logic               show;

  assign line_evt = (VGA_VCOUNT != vcount_q);
  assign commit   = line_evt && (VGA_VCOUNT == V_ACT10);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign t_next   = (VGA_VCOUNT == V_LAST10) ? 10'd0 : VGA_VCOUNT + 10'd1;

  assign t11     = {1'b0, t_q};
  assign sy11    = {1'b0, act_y_q[idx_q]};
  assign hit     = act_en_q[idx_q] && (t11 >= sy11) && (t11 <= sy11 + SIZE_M1_11);
  assign row_off = SW'(t_q - act_y_q[idx_q]);
  assign cnt_inc = cnt_q + 11'd1;
  // In FETCH, the data arriving now belongs to the column requested one clk earlier.
  assign wx      = {1'b0, act_x_q[idx_q]} + (cnt_q - 11'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shd_en_q[i] <= 1'b0;
        shd_x_q[i]  <= '0;
        shd_y_q[i]  <= '0;
        act_en_q[i] <= 1'b0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make the commit copy see pre-edge shadow
      // values, so a write in the commit clk lands in the shadow set only.
      if (commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_en_q[i] <= shd_en_q[i];
          act_x_q[i]  <= shd_x_q[i];
          act_y_q[i]  <= shd_y_q[i];
        end
      end
      if (desc_we) begin
        shd_en_q[desc_addr] <= desc_data[20];
        shd_x_q[desc_addr]  <= desc_data[19:10];
        shd_y_q[desc_addr]  <= desc_data[9:0];
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    row_d      = row_q;
    rendered_d = rendered_q;
    pix_rd_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    wr_en      = 1'b0;
    wr_addr    = cnt_q[HW-1:0];
    wr_data    = BG_COLOR;
    if (line_evt) begin
      t_d     = t_next;
      cnt_d   = '0;
      state_d = (t_next < V_ACT10) ? S_CLEAR : S_IDLE;
    end else begin
      case (state_q)
        S_CLEAR: begin
          wr_en = 1'b1;
          if (cnt_q == H_LAST11) begin
            state_d                 = S_SCAN;
            idx_d                   = IDX_LAST;
            rendered_d[~disp_sel_q] = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SCAN: begin
          if (hit) begin
            state_d    = S_FETCH;
            cnt_d      = '0;
            row_d      = row_off;
            pix_rd_d   = 1'b1;
            pix_addr_d = {idx_q, row_off, {SW{1'b0}}};
          end else if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        S_FETCH: begin
          if (cnt_q != '0 && pix_data != TRANSPARENT && wx < H_ACT11) begin
            wr_en   = 1'b1;
            wr_addr = wx[HW-1:0];
            wr_data = pix_data;
          end
          if (cnt_q == SIZE11) begin
            if (idx_q == '0) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q - 1'b1;
              state_d = S_SCAN;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < SIZE11) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = {idx_q, row_q, cnt_inc[SW-1:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The buffer being displayed switches in the line-event clk itself.
  assign disp_now = disp_sel_q ^ line_evt;
  assign hcount11 = {1'b0, VGA_HCOUNT};
  assign disp_pix = disp_now ? lb1_mem[hcount11[HW-1:0]] : lb0_mem[hcount11[HW-1:0]];
  assign show     = (hcount11 < H_ACT11) && (VGA_VCOUNT < V_ACT10) && rendered_q[disp_now];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcount_q   <= '0;
      disp_sel_q <= 1'b0;
      rendered_q <= '0;
      overrun_q  <= 1'b0;
      state_q    <= S_IDLE;
      t_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      vga_q      <= '0;
    end else begin
      vcount_q <= VGA_VCOUNT;
      if (line_evt) begin
        disp_sel_q <= ~disp_sel_q;
        if (busy) overrun_q <= 1'b1;
      end
      rendered_q <= rendered_d;
      state_q    <= state_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      vga_q      <= show ? disp_pix : '0;
    end
  end

  // NOTE: line buffers are not reset; rendered_q masks never-written content,
  // which keeps them mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !disp_sel_q) lb1_mem[wr_addr] <= wr_data;
    if (wr_en &&  disp_sel_q) lb0_mem[wr_addr] <= wr_data;
  end

  assign pix_rd   = pix_rd_q;
  assign pix_addr = pix_addr_q;
  assign overrun  = overrun_q;
  assign VGA_R    = vga_q[3*CW-1:2*CW];
  assign VGA_G    = vga_q[2*CW-1:CW];
  assign VGA_B    = vga_q[CW-1:0];

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: a behavioural sprite model predicts
// every displayed pixel, queued on drive and compared one clk later.
module tb_sprite_line_renderer;

  localparam int LINE = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        desc_we = 1'b0;
  logic [2:0]  desc_addr = '0;
  logic [20:0] desc_data = '0;
  logic [9:0]  VGA_HCOUNT = '0;
  logic [9:0]  VGA_VCOUNT = '0;
  logic [12:0] pix_addr;
  logic        pix_rd;
  logic [23:0] pix_data = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int cur_v = 0;
  int ok_line = -1;

  bit          shd_en [8];
  int          shd_x  [8];
  int          shd_y  [8];
  bit          act_en [8];
  int          act_x  [8];
  int          act_y  [8];
  logic [23:0] spr_color [8];
  bit          spr_pat   [8];
  int          spr_tcols [8];

  typedef struct {
    int          v;
    int          h;
    logic [23:0] pix;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sprite_line_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .desc_we    (desc_we),
    .desc_addr  (desc_addr),
    .desc_data  (desc_data),
    .VGA_HCOUNT (VGA_HCOUNT),
    .VGA_VCOUNT (VGA_VCOUNT),
    .pix_addr   (pix_addr),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .overrun    (overrun)
  );

  function automatic logic [23:0] mem_pix(int s, int row, int col);
    if (col < spr_tcols[s]) return 24'h000000;
    if (spr_pat[s]) return {8'(8'h40 + row), 8'(8'h80 + col), 8'(s + 1)};
    return spr_color[s];
  endfunction

  // Sprite pixel memory: one clk read latency.
  always @(posedge clk) begin
    if (pix_rd === 1'b1) begin
      pix_data <= mem_pix(int'(pix_addr[12:10]), int'(pix_addr[9:5]), int'(pix_addr[4:0]));
      rd_cnt   <= rd_cnt + 1;
    end
  end

  function automatic logic [23:0] model_pix(int v, int h);
    logic [23:0] p;
    if (v >= 480 || h >= 640) return 24'h000000;
    for (int s = 0; s < 8; s++) begin
      if (act_en[s] && v >= act_y[s] && v <= act_y[s] + 31 &&
          h >= act_x[s] && h <= act_x[s] + 31) begin
        p = mem_pix(s, v - act_y[s], h - act_x[s]);
        if (p != 24'h000000) return p;
      end
    end
    return 24'h000000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("pix v%0d h%0d", e.v, e.h), {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e.pix});
    end
  endtask

  task automatic run_line(input int v, input int len, input bit chk);
    bit   evt;
    bit   valid;
    int   t;
    exp_t e;
    evt   = (v != cur_v);
    valid = evt && (ok_line == v);
    t     = (v == 524) ? 0 : v + 1;
    if (evt && v == 480) begin
      for (int s = 0; s < 8; s++) begin
        act_en[s] = shd_en[s];
        act_x[s]  = shd_x[s];
        act_y[s]  = shd_y[s];
      end
    end
    cur_v = v;
    for (int h = 0; h < len; h++) begin
      VGA_VCOUNT = 10'(v);
      VGA_HCOUNT = 10'(h);
      if (chk) begin
        e.v   = v;
        e.h   = h;
        e.pix = valid ? model_pix(v, h) : 24'h000000;
        exp_q.push_back(e);
      end
      tick();
    end
    ok_line = (evt && len >= LINE && t < 480) ? t : -1;
  endtask

  task automatic write_desc(input int s, input bit en, input int x, input int y);
    desc_we   = 1'b1;
    desc_addr = 3'(s);
    desc_data = {en, 10'(x), 10'(y)};
    shd_en[s] = en;
    shd_x[s]  = x;
    shd_y[s]  = y;
    tick();
    desc_we   = 1'b0;
  endtask

  initial begin
    int rd0;
    for (int s = 0; s < 8; s++) begin
      spr_color[s] = 24'h000000;
      spr_pat[s]   = 1'b0;
      spr_tcols[s] = 0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("rst_pix_rd", 32'(pix_rd), 32'h0);
    check("rst_pix_addr", 32'(pix_addr), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Three lines with nothing enabled.
    run_line(0, LINE, 1);
    run_line(1, LINE, 1);
    run_line(2, LINE, 1);
    check("no_pix_rd", 32'(rd_cnt), 32'h0);
    check("no_overrun", 32'(overrun), 32'h0);

    // Single red sprite 3 at (100,50).
    spr_color[3] = 24'hFF0000;
    write_desc(3, 1'b1, 100, 50);
    run_line(480, 20, 0);
    run_line(48, LINE, 0);
    rd0 = rd_cnt;
    run_line(49, LINE, 1);
    check("reads_line50", 32'(rd_cnt - rd0), 32'd32);
    run_line(50, LINE, 1);
    run_line(81, LINE, 0);
    run_line(82, LINE, 1);

    // Overlapping sprites 0 (green, on top) and 1 (blue).
    write_desc(3, 1'b0, 100, 50);
    spr_color[0] = 24'h00FF00;
    spr_color[1] = 24'h0000FF;
    write_desc(0, 1'b1, 200, 10);
    write_desc(1, 1'b1, 200, 10);
    run_line(480, 20, 0);
    run_line(9, LINE, 0);
    run_line(10, LINE, 1);
    run_line(11, LINE, 1);
    spr_tcols[0] = 4;
    run_line(12, LINE, 0);
    run_line(13, LINE, 1);

    // Right-edge clipping, bottom-edge clipping and the wrap to line 0.
    write_desc(0, 1'b0, 200, 10);
    write_desc(1, 1'b0, 200, 10);
    spr_pat[5]   = 1'b1;
    spr_color[6] = 24'h123456;
    write_desc(5, 1'b1, 620, 470);
    write_desc(6, 1'b1, 10, 0);
    run_line(480, 20, 0);
    run_line(469, LINE, 0);
    run_line(470, LINE, 1);
    run_line(478, LINE, 0);
    run_line(479, LINE, 1);
    run_line(480, LINE, 1);
    run_line(481, LINE, 1);
    run_line(524, LINE, 0);
    run_line(0, LINE, 1);
    run_line(1, LINE, 1);

    // Mid-frame descriptor write stays invisible until the next vblank.
    spr_color[2] = 24'hFFFFFF;
    run_line(99, LINE, 0);
    run_line(100, LINE, 0);
    write_desc(2, 1'b1, 300, 102);
    run_line(101, LINE, 0);
    run_line(102, LINE, 1);
    run_line(480, 20, 0);
    run_line(101, LINE, 0);
    run_line(102, LINE, 1);

    // Eight overlapping sprites; a short line forces an overrun.
    for (int s = 0; s < 8; s++) begin
      spr_color[s] = {8'(10 + s * 30), 8'(255 - s), 8'h5A};
      spr_pat[s]   = 1'b0;
      spr_tcols[s] = 0;
      write_desc(s, 1'b1, 50 + s * 24, 200);
    end
    run_line(480, 20, 0);
    check("overrun_before", 32'(overrun), 32'h0);
    run_line(199, LINE, 0);
    run_line(200, 300, 0);
    run_line(201, LINE, 0);
    check("overrun_set", 32'(overrun), 32'h1);
    run_line(202, LINE, 1);
    run_line(203, LINE, 1);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Asynchronous reset while a fetch is in progress.
    run_line(210, 700, 0);
    check("pix_rd_mid", 32'(pix_rd), 32'h1);
    reset = 1'b1;
    #1;
    check("arst_pix_rd", 32'(pix_rd), 32'h0);
    check("arst_pix_addr", 32'(pix_addr), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    check("arst_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
    #2 reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Parametrised, double-buffered scanline sprite renderer for the VGA path.
- While line v is displayed from one line buffer, it renders line v+1 into the other buffer from up to NUM_SPRITES descriptors. Lower sprite index has higher priority, and one colour is treated as transparent.
- Sits between the Avalon descriptor registers, the sprite pixel ROM/RAM and the VGA DAC outputs.

Parameters:
- NUM_SPRITES, 8, number of sprite descriptors (power of 2, 2..32).
- SPRITE_SIZE, 32, sprite width and height in pixels (power of 2).
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- COLOR_W, 24, pixel width as {R,G,B}; each component is COLOR_W/3 bits.
- TRANSPARENT, 24'h000000, colour key; pixels with this value are never written.
- BG_COLOR, 24'h000000, line buffer clear value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- desc_we  in  1  descriptor write strobe.
- desc_addr  in  $clog2(NUM_SPRITES)  descriptor index.
- desc_data  in  21  {enable[20], x[19:10], y[9:0]}; x and y give the sprite's top-left corner.
- VGA_HCOUNT  in  10  current pixel column.
- VGA_VCOUNT  in  10  current line.
- pix_addr  out  $clog2(NUM_SPRITES)+2*$clog2(SPRITE_SIZE)  {sprite, row, col} address into pixel memory.
- pix_rd  out  1  pixel read strobe.
- pix_data  in  COLOR_W  pixel memory data; valid exactly 1 clk after pix_rd.
- VGA_R, VGA_G, VGA_B  out  COLOR_W/3 each  registered colour outputs.
- overrun  out  1  sticky flag; set when a render is aborted by a line change.

Behaviour:
- Reset values:
  - All outputs are 0.
  - All descriptors (both sets) are disabled.
  - Display buffer select is 0 and the FSM is in IDLE.
  - Line buffer contents are don't-care.
- Descriptors:
  - desc_we writes the shadow set at any time.
  - The shadow set is copied to the active set in the clk where VGA_VCOUNT first equals V_ACTIVE (start of vblank). A descriptor write in that same clk lands in the shadow only.
  - Rendering reads only the active set.
- Line event: a one-clk pulse is generated when VGA_VCOUNT differs from its registered copy. On a line event:
  - The display/render buffer roles swap.
  - The target line is t = VGA_VCOUNT+1, wrapping V_TOTAL-1 to 0.
  - If t < V_ACTIVE the FSM enters CLEAR; otherwise it goes to IDLE.
- FSM states:
  - IDLE: wait for a line event.
  - CLEAR: write BG_COLOR to render-buffer entries 0..H_ACTIVE-1, one per clk (H_ACTIVE clks). Then set i = NUM_SPRITES-1 and enter SCAN.
  - SCAN (1 clk per sprite):
    - If sprite i is enabled and y <= t <= y+SPRITE_SIZE-1 (computed in 11 bits, no wrap), go to FETCH with col = 0.
    - Otherwise, if i == 0 go to DONE; else decrement i and stay in SCAN.
  - FETCH:
    - Issue pix_rd with addr {i, t-y, col} for col = 0..SPRITE_SIZE-1, one per clk.
    - 1 clk later, write pix_data to render[x+col] if pix_data != TRANSPARENT and x+col < H_ACTIVE (11-bit sum; off-screen pixels are dropped).
    - After the final write, if i == 0 go to DONE; else decrement i and return to SCAN. FETCH takes SPRITE_SIZE+1 clks.
  - DONE: hold until the next line event.
- Priority: sprites are drawn in descending index order, so sprite 0 is drawn last and appears on top.
- Overrun: a line event in any state other than IDLE or DONE sets overrun and aborts the render; the swap and new render proceed normally. overrun clears only on reset.
- Worst-case render time is H_ACTIVE + NUM_SPRITES*(SPRITE_SIZE+2) + 2 clks. The line period in clk cycles must exceed this.
- Output stage:
  - 1-clk latency: VGA_R/G/B <= display[VGA_HCOUNT] split into {R,G,B}.
  - Outputs are 0 when VGA_HCOUNT >= H_ACTIVE, VGA_VCOUNT >= V_ACTIVE, or the displayed line was never rendered since reset.
- pix_rd is 0 outside FETCH, and pix_addr holds its last value.
- Reset asserted mid-render returns everything to the reset state asynchronously.

Test Plan:
- Reset, then 3 lines with no sprites enabled -> VGA_R/G/B = 0 on every pixel; pix_rd never asserted; overrun = 0.
- Sprite 3 at (x=100, y=50) with solid 24'hFF0000 pixels, committed through a vblank -> on line 50, pixels 100..131 read R=FF, G=0, B=0, with 0 elsewhere; lines 49 and 82 are all 0.
- Sprites 0 and 1 both at (200,10); sprite 0 solid 24'h00FF00, sprite 1 solid 24'h0000FF -> pixels 200..231 read G=FF only. Then make sprite 0's pixels at cols 0..3 equal TRANSPARENT -> pixels 200..203 show B=FF.
- Sprite at x=620 -> pixels 620..639 drawn, no write beyond index 639. Sprite at y=470 -> rows 470..479 drawn and lines 480+ output 0. t=0 is rendered during line V_TOTAL-1.
- Descriptor write to sprite 2 mid-frame (vcount=100) -> frame unchanged until vblank; new position visible from the next frame's first matching line.
- Line events 300 clks apart with 8 sprites active -> overrun = 1 and stays 1; the next line event with adequate spacing renders correctly.
